// File: rtl/adc_frame_sequencer_if.sv
// adc_frame_sequencer_if
// Byte stream towards the host link: packet bytes with valid/ready
// handshake and an end-of-packet marker.
interface adc_frame_sequencer_if;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic       m_last;

  modport master (output m_data, output m_valid, output m_last, input m_ready);
  modport slave  (input m_data, input m_valid, input m_last, output m_ready);
endinterface

// File: rtl/adc_frame_sequencer.sv
// adc_frame_sequencer
// Runs the shared integrating-ADC counter for a number of 311-cycle frames,
// tracks the counter's phase locally, drops the stale first readout window
// and streams framed packets (0xA5, frame index, 128 samples) out of a FIFO.
module adc_frame_sequencer #(
  parameter int NUM_CH     = 128,
  parameter int FRAME_LEN  = 311,
  parameter int FIFO_DEPTH = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         stop,
  input  logic [15:0]                  num_frames,
  input  logic                         debug_cfg,
  output logic                         adc_enable,
  output logic                         adc_debug_mux,
  input  logic [7:0]                   adc_data,
  input  logic                         adc_update,
  adc_frame_sequencer_if.master        m_if,
  output logic                         busy,
  output logic [15:0]                  frames_done,
  output logic                         overflow,
  output logic                         sync_err
);

  localparam int PW = $clog2(FRAME_LEN);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [PW-1:0] P_LAST    = PW'(FRAME_LEN - 1);
  localparam logic [PW-1:0] P_DECIDE  = PW'(FRAME_LEN - 2);
  localparam logic [PW-1:0] P_CH_LAST = PW'(NUM_CH);
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
  localparam logic [7:0]    HEADER    = 8'hA5;

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [PW-1:0] p;
  logic [16:0]   fc;
  logic [15:0]   nf_q;
  logic          stop_pending;
  logic          start_ok;
  logic          end_now;
  logic          window;
  logic          push_valid;
  logic [7:0]    push_data;
  logic          push_last;
  logic          pop;
  logic          full_block;
  logic          accept;
  logic [8:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;

  // Readout window: counter phases 1..NUM_CH carry channel p-1.
  assign window = adc_enable && (p != '0) && (p <= P_CH_LAST);

  // Sequencer state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state; the run-end decision is taken one cycle before the frame
  // wraps so that enable can drop exactly on the 310->0 edge.
  always_comb begin
    state_nxt = state;
    start_ok  = 1'b0;
    end_now   = 1'b0;
    case (state)
      IDLE: begin
        if (start && !busy) begin
          start_ok  = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (p == P_DECIDE) begin
          end_now = stop_pending || stop ||
                    ((nf_q != 16'd0) && (fc == ({1'b0, nf_q} + 17'd1)));
          if (end_now) state_nxt = FINISH;
        end
      end
      FINISH: begin
        if (p == P_LAST) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Phase/frame counters mirroring the ADC counter, plus run configuration.
  // fc is 1 during the first enabled frame and saturates in long continuous runs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      adc_enable    <= 1'b0;
      adc_debug_mux <= 1'b0;
      p             <= '0;
      fc            <= '0;
      nf_q          <= '0;
      stop_pending  <= 1'b0;
    end else if (start_ok) begin
      adc_enable    <= 1'b1;
      adc_debug_mux <= debug_cfg;
      p             <= '0;
      fc            <= 17'd1;
      nf_q          <= num_frames;
      stop_pending  <= 1'b0;
    end else begin
      if (state == FINISH && p == P_LAST) begin
        adc_enable <= 1'b0;
        p          <= '0;
      end else if (adc_enable) begin
        if (p == P_LAST) begin
          p <= '0;
          if (fc != '1) fc <= fc + 17'd1;
        end else begin
          p <= p + PW'(1);
        end
      end
      if (state == RUN && stop) stop_pending <= 1'b1;
    end
  end

  // Select what (if anything) enters the FIFO this cycle: a sample from a
  // non-stale window, the header, or the frame index byte.
  always_comb begin
    push_valid = 1'b0;
    push_data  = 8'h00;
    push_last  = 1'b0;
    if (window && fc >= 17'd2) begin
      push_valid = 1'b1;
      push_data  = adc_data;
      push_last  = (p == P_CH_LAST);
    end else if (state == RUN && p == P_DECIDE && !end_now && fc >= 17'd1) begin
      push_valid = 1'b1;
      push_data  = HEADER;
    end else if (state == RUN && p == P_LAST && fc >= 17'd1) begin
      push_valid = 1'b1;
      push_data  = frames_done[7:0];
    end
  end

  // A pop frees a slot before the push is judged, so full+pop+push succeeds.
  assign pop        = m_if.m_valid && m_if.m_ready;
  assign full_block = (count == DEPTH_C) && !pop;
  assign accept     = push_valid && !full_block;

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + AW'(1);
      if (pop)    rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(accept) - CW'(pop);
    end
  end

  // FIFO storage; contents need no reset because occupancy gates the output.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= {push_last, push_data};
  end

  assign m_if.m_valid = (count != '0);
  assign m_if.m_data  = m_if.m_valid ? mem[rd_ptr][7:0] : 8'h00;
  assign m_if.m_last  = m_if.m_valid && mem[rd_ptr][8];

  // Run status: busy tracks the upcoming state so it rises right after start,
  // and the sticky error flags clear only when a new run begins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy        <= 1'b0;
      frames_done <= '0;
      overflow    <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      busy <= (state_nxt != IDLE) || (count != '0);
      if (start_ok) begin
        frames_done <= '0;
        overflow    <= 1'b0;
        sync_err    <= 1'b0;
      end else begin
        if (push_valid && push_last) frames_done <= frames_done + 16'd1;
        if (push_valid && full_block) overflow <= 1'b1;
        if (window && !adc_update) sync_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_adc_frame_sequencer.sv
// tb_adc_frame_sequencer
// Drives a behavioural ADC counter model and compares the emitted packet
// stream and status against packets predicted from frame-level rules.
module tb_adc_frame_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic        stop;
  logic [15:0] num_frames;
  logic        debug_cfg;
  logic        adc_enable;
  logic        adc_debug_mux;
  logic [7:0]  adc_data;
  logic        adc_update;
  logic        busy;
  logic [15:0] frames_done;
  logic        overflow;
  logic        sync_err;

  int checks;
  int errors;
  int dMul;
  int dSalt;

  adc_frame_sequencer_if m_if ();

  adc_frame_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .stop          (stop),
    .num_frames    (num_frames),
    .debug_cfg     (debug_cfg),
    .adc_enable    (adc_enable),
    .adc_debug_mux (adc_debug_mux),
    .adc_data      (adc_data),
    .adc_update    (adc_update),
    .m_if          (m_if),
    .busy          (busy),
    .frames_done   (frames_done),
    .overflow      (overflow),
    .sync_err      (sync_err)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for every check in the bench.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Counter result for channel c in the window of 0-based enabled frame f.
  function automatic logic [7:0] dataOf(input int f, input int c);
    return 8'((c * dMul + 16 * f + dSalt) & 255);
  endfunction

  // Runs one capture session and checks it against the predicted packets.
  // readyMode 0 holds m_ready low until the counter stops, then drains.
  task automatic applyStimulus(input int nf, input int stopAt, input int readyMode, input int dropCh);
    logic [7:0] expQ[$];
    logic       expL[$];
    logic [7:0] gotQ[$];
    logic       gotL[$];
    int  k, cyc, fellCyc, nFrames, fs, nPk, f, ph, n;
    bit  enSeen, enFell, dropped, timedOut;
    logic dbg;

    nFrames = (nf == 0) ? 1000000 : nf + 1;
    if (stopAt >= 0) begin
      fs = ((stopAt % 311) <= 309) ? stopAt / 311 + 1 : stopAt / 311 + 2;
      if (fs < nFrames) nFrames = fs;
    end
    nPk = nFrames - 1;
    for (int j = 0; j < nPk; j++) begin
      expQ.push_back(8'hA5);    expL.push_back(1'b0);
      expQ.push_back(8'(j));    expL.push_back(1'b0);
      for (int c = 0; c < 128; c++) begin
        expQ.push_back(dataOf(j + 1, c));
        expL.push_back(c == 127);
      end
    end
    if (readyMode == 0) begin
      while (expQ.size() > 32) begin
        void'(expQ.pop_back());
        void'(expL.pop_back());
      end
    end

    k = 0; cyc = 0; fellCyc = 0;
    enSeen = 0; enFell = 0; dropped = 0; timedOut = 0;
    dbg = 1'($urandom_range(0, 1));
    @(negedge clk);
    start = 1'b1;
    num_frames = 16'(nf);
    debug_cfg = dbg;
    m_if.m_ready = (readyMode != 0);

    while (1) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      stop  = 1'b0;
      if (cyc == 1) begin
        checkOutput("busy_rise", 32'(busy), 1);
        checkOutput("enable_rise", 32'(adc_enable), 1);
        checkOutput("debug_mux", 32'(adc_debug_mux), 32'(dbg));
      end
      if (adc_enable) begin
        ph = k % 311;
        f  = k / 311;
        if (ph >= 1 && ph <= 128) begin
          adc_data   = dataOf(f, ph - 1);
          adc_update = !(f == 1 && (ph - 1) == dropCh);
          if (!adc_update) dropped = 1;
        end else begin
          adc_data   = 8'($urandom);
          adc_update = 1'($urandom);
        end
        stop = (k == stopAt);
        if (k == 500) begin
          start = 1'b1;
          num_frames = 16'(nf + 3);
        end
        k++;
        enSeen = 1;
      end else begin
        adc_data   = 8'($urandom);
        adc_update = 1'($urandom);
        if (enSeen && !enFell) begin
          enFell  = 1;
          fellCyc = cyc;
        end
      end
      if (readyMode == 0) m_if.m_ready = enFell && (cyc - fellCyc > 5);
      else                m_if.m_ready = ($urandom_range(0, 15) != 0);
      if (m_if.m_valid && m_if.m_ready) begin
        gotQ.push_back(m_if.m_data);
        gotL.push_back(m_if.m_last);
      end
      if (enSeen && !adc_enable && !busy) break;
      if (cyc > 6000) begin
        timedOut = 1;
        break;
      end
    end

    checkOutput("timeout", 32'(timedOut), 0);
    checkOutput("enabled_cycles", k, 311 * nFrames);
    checkOutput("frames_done", 32'(frames_done), nPk);
    checkOutput("overflow", 32'(overflow), (readyMode == 0 && 130 * nPk > 32) ? 1 : 0);
    checkOutput("sync_err", 32'(sync_err), 32'(dropped));
    checkOutput("byte_count", gotQ.size(), expQ.size());
    n = (gotQ.size() < expQ.size()) ? gotQ.size() : expQ.size();
    for (int i = 0; i < n; i++) begin
      checkOutput("byte", 32'(gotQ[i]), 32'(expQ[i]));
      checkOutput("last", 32'(gotL[i]), 32'(expL[i]));
    end
  endtask

  // Asserts reset in the middle of frame fc=2 (phase 50) with a full FIFO.
  task automatic resetMidRun();
    int k;
    k = 0;
    @(negedge clk);
    start = 1'b1;
    num_frames = 16'd0;
    debug_cfg = 1'b1;
    m_if.m_ready = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (adc_enable) begin
        if (k == 311 + 50) break;
        adc_data   = 8'($urandom);
        adc_update = 1'b1;
        k++;
      end
    end
    checkOutput("reset_reach", k, 361);
    checkOutput("pre_reset_ovf", 32'(overflow), 1);
    reset = 1'b1;
    #1;
    checkOutput("rst_enable", 32'(adc_enable), 0);
    checkOutput("rst_mux", 32'(adc_debug_mux), 0);
    checkOutput("rst_valid", 32'(m_if.m_valid), 0);
    checkOutput("rst_data", 32'(m_if.m_data), 0);
    checkOutput("rst_last", 32'(m_if.m_last), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_frames", 32'(frames_done), 0);
    checkOutput("rst_ovf", 32'(overflow), 0);
    checkOutput("rst_sync", 32'(sync_err), 0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Directed scenarios followed by randomized sessions.
  initial begin
    int nf, stopAt, dropCh;
    checks = 0;
    errors = 0;
    dMul = 1;
    dSalt = 0;
    reset = 1'b1;
    start = 1'b0;
    stop = 1'b0;
    num_frames = 16'd0;
    debug_cfg = 1'b0;
    adc_data = 8'h00;
    adc_update = 1'b0;
    m_if.m_ready = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("init_enable", 32'(adc_enable), 0);
    checkOutput("init_mux", 32'(adc_debug_mux), 0);
    checkOutput("init_valid", 32'(m_if.m_valid), 0);
    checkOutput("init_data", 32'(m_if.m_data), 0);
    checkOutput("init_last", 32'(m_if.m_last), 0);
    checkOutput("init_busy", 32'(busy), 0);
    checkOutput("init_frames", 32'(frames_done), 0);
    checkOutput("init_ovf", 32'(overflow), 0);
    checkOutput("init_sync", 32'(sync_err), 0);
    reset = 1'b0;

    applyStimulus(2, -1, 1, -1);
    applyStimulus(0, 2 * 311 + 200, 1, -1);
    applyStimulus(0, 311 + 309, 1, -1);
    applyStimulus(1, -1, 0, -1);
    resetMidRun();
    applyStimulus(1, -1, 1, -1);
    applyStimulus(2, -1, 1, 5);

    for (int r = 0; r < 5; r++) begin
      dMul  = $urandom_range(0, 127) * 2 + 1;
      dSalt = $urandom_range(0, 255);
      if (r == 4) begin
        nf = 0;
        stopAt = $urandom_range(0, 3 * 311 - 1);
      end else begin
        nf = $urandom_range(1, 3);
        stopAt = ($urandom_range(0, 1) != 0) ? -1 : $urandom_range(0, 311 * (nf + 1) - 1);
      end
      dropCh = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 127) : -1;
      $display("[TB] random run %0d nf=%0d stopAt=%0d dropCh=%0d", r, nf, stopAt, dropCh);
      applyStimulus(nf, stopAt, 1, dropCh);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adc_frame_sequencer.md
# adc_frame_sequencer

Controls the shared integrating-ADC counter block. It drives the counter's enable and debug-mux inputs and tracks the counter's 311-cycle conversion frame with a local phase counter. It discards the stale first readout window, captures the 128-channel readout stream, and emits framed byte packets (2-byte header plus 128 samples) through a FIFO with a valid/ready interface towards the host link.

## Interface
- NUM_CH, 128: channels per readout window.
- FRAME_LEN, 311: counter frame length in cycles (phase 0..310).
- FIFO_DEPTH, 32: output FIFO entries (power of 2).
- clk  in  1  system clock, same clock as the ADC counter.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse; begins a run; ignored while busy.
- stop  in  1  single-cycle pulse; requests end of run at the next frame boundary.
- num_frames  in  16  frames to capture, sampled at start; 0 means continuous until stop.
- debug_cfg  in  1  sampled at start; forwarded as adc_debug_mux.
- adc_enable  out  1  enable to the ADC counter.
- adc_debug_mux  out  1  debug select to the ADC counter.
- adc_data  in  8  counter output byte.
- adc_update  in  1  counter output-valid flag.
- m_data  out  8  packet byte.
- m_valid  out  1  m_data valid.
- m_ready  in  1  consumer accepts when high together with m_valid.
- m_last  out  1  marks the final byte (channel NUM_CH-1) of a packet.
- busy  out  1  high while a run is active or the FIFO is non-empty.
- frames_done  out  16  packets fully enqueued in the current run.
- overflow  out  1  sticky; a byte was dropped because the FIFO was full.
- sync_err  out  1  sticky; adc_update was low during a capture cycle.

## Operation
- States: IDLE, RUN, FINISH.
- IDLE → RUN on start while not busy:
  - latch num_frames and debug_cfg;
  - clear frames_done, overflow, sync_err and fc (frame-cycle count);
  - set adc_enable=1 (registered) and p=0.
- Phase counter p mirrors the counter's main count:
  - increments on every edge while adc_enable=1;
  - wraps 310→0, and fc increments on that wrap;
  - fc=1 during the first frame cycle;
  - held at 0 while adc_enable=0.
- Capture window:
  - active when adc_enable=1 and p in 1..128; the sample for channel p-1 is adc_data.
  - The fc=1 window is stale data and is discarded. Windows with fc≥2 carry the results of frame fc-1 and are pushed.
  - adc_update=0 in any capture cycle sets sync_err; the byte is still pushed.
- End-of-run decision, made at p==309:
  - end if stop_pending is set (including a stop arriving in that same cycle);
  - or if num_frames≠0 and fc==num_frames+1.
- If not ending at p==309:
  - when fc≥1, push header byte 0xA5 at p==309 and frames_done[7:0] at p==310.
- If ending: no header is pushed, go to FINISH. adc_enable falls on the p==310→0 edge, so the counter's last enabled edge sees count 310 and its integrator is held in reset. Then go to IDLE.
- frames_done increments when channel NUM_CH-1 is pushed (or dropped); m_last is set on that entry.
- A push into a full FIFO drops the byte, sets overflow, and leaves frames_done counting unaffected.
- The FIFO pops when m_valid&&m_ready. Push and pop in the same cycle on a full FIFO: the pop is performed first, so the push succeeds.
- stop while IDLE: ignored. start while busy: ignored.
- Reset mid-run: all state returns to reset values, the FIFO is emptied, and adc_enable drops immediately.

## Timing
- Reset values: adc_enable=0, adc_debug_mux=0, m_data=0, m_valid=0, m_last=0, busy=0, frames_done=0, overflow=0, sync_err=0.
- busy rises the cycle after start and falls the cycle after the FIFO empties in IDLE.
- Samples land in the FIFO one cycle after the capture cycle.
- m_valid rises one cycle after the first push into an empty FIFO.
- Run length for num_frames=N: (N+1)·311 enabled cycles.
- Packet length is 130 bytes (0xA5, frame index, 128 samples).
- Sustained packet rate is 130 bytes per 311 cycles; the burst rate is 1 byte/cycle for 128 cycles.

## Test plan
- num_frames=2, m_ready=1, counter model returns channel value c+16·frame:
  - 622+311 enabled cycles; the first window is discarded;
  - two packets: A5,00,16..143 and A5,01,32..159;
  - frames_done=2, then busy falls.
- num_frames=0, stop at fc=3 p=200:
  - two packets emitted;
  - adc_enable falls at the 310→0 edge of fc=3;
  - no third header.
- stop exactly at p==309 of fc=2:
  - run ends after fc=2;
  - one packet only.
- m_ready=0 throughout, num_frames=1:
  - FIFO holds 32 bytes (A5,00,samples 0..29);
  - overflow=1 and frames_done=1;
  - releasing m_ready drains exactly 32 bytes.
- Assert reset at fc=2 p=50:
  - all outputs at reset values the same cycle;
  - a subsequent start runs cleanly.
- Hold adc_update=0 in the channel 5 capture cycle:
  - sync_err=1;
  - packet still 130 bytes.
